// File: rtl/mux_rr_n_if.sv
// mux_rr_n_if: channel bundle for mux_rr_n.
// Ports (signals):
//   in_data  N*W  input words, channel k at [k*W +: W]
//   in_valid N    per-channel word offered
//   in_ready N    one-hot, channel word taken this cycle
//   mode     1    0 = explicit select, 1 = round-robin
//   sel      SW   channel index used when mode=0
//   out_data W    registered selected word
//   out_valid 1   out_data holds an untaken word
//   out_ready 1   downstream accepts out_data
//   out_src  SW   channel that produced out_data
// The slave modport is the mux view; master is the surrounding logic.
interface mux_rr_n_if #(
   parameter int W = 32,
   parameter int N = 4
);
   localparam int SW = $clog2(N);
   logic [N*W-1:0] in_data;
   logic [N-1:0]   in_valid;
   logic [N-1:0]   in_ready;
   logic           mode;
   logic [SW-1:0]  sel;
   logic [W-1:0]   out_data;
   logic           out_valid;
   logic           out_ready;
   logic [SW-1:0]  out_src;
   modport master (
      output in_data, in_valid, mode, sel, out_ready,
      input  in_ready, out_data, out_valid, out_src
   );
   modport slave (
      input  in_data, in_valid, mode, sel, out_ready,
      output in_ready, out_data, out_valid, out_src
   );
endinterface

// File: rtl/mux_rr_n.sv
// mux_rr_n: N-input W-bit registered mux, explicit select or round-robin.
// Ports:
//   clk   rising-edge clock
//   rst_n asynchronous active-low reset
//   bus   mux_rr_n_if.slave (input channels, select, registered output)
module mux_rr_n #(
   parameter int W = 32,
   parameter int N = 4
) (
   input logic      clk,
   input logic      rst_n,
   mux_rr_n_if.slave bus
);
   localparam int SW = $clog2(N);
   logic [SW-1:0] last;
   logic [SW-1:0] g;
   logic [SW-1:0] idx;
   logic          found;
   logic          le;
   assign le = !bus.out_valid || bus.out_ready;
   // Round-robin scans last+1 .. last (mod N); explicit select only matches
   // in-range indices so an out-of-range sel simply yields no grant.
   always_comb begin
      found = 1'b0;
      g = '0;
      idx = '0;
      for (int i = 1; i <= N; i++) begin
         idx = SW'((int'(last) + i) % N);
         if (bus.mode && !found && bus.in_valid[idx]) begin
            found = 1'b1;
            g = idx;
         end
      end
      for (int k = 0; k < N; k++) begin
         if (!bus.mode && bus.sel == SW'(k) && bus.in_valid[SW'(k)]) begin
            found = 1'b1;
            g = SW'(k);
         end
      end
   end
   // Gated by rst_n so no channel sees a handshake while reset is held.
   assign bus.in_ready = (rst_n && found && le) ? (N'(1) << g) : '0;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.out_valid <= 1'b0;
         bus.out_data <= '0;
         bus.out_src <= '0;
         last <= SW'(N - 1);
      end else if (le) begin
         bus.out_valid <= found;
         if (found) begin
            bus.out_data <= bus.in_data[int'(g)*W +: W];
            bus.out_src <= g;
            last <= g;
         end
      end
   end
endmodule

// File: tb/tb_mux_rr_n.sv
// tb_mux_rr_n: directed and randomized checks of mux_rr_n against a reference model.
module tb_mux_rr_n;
   localparam int N = 4;
   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int errors = 0;
   int checks = 0;
   always #5 clk = ~clk;
   mux_rr_n_if #(.W(32), .N(4)) b4 ();
   mux_rr_n_if #(.W(32), .N(3)) b3 ();
   mux_rr_n #(.W(32), .N(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b4));
   mux_rr_n #(.W(32), .N(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));
   // Reference model of the N=4 instance: output register plus last-grant pointer.
   logic        m_valid;
   logic [31:0] m_data;
   int          m_src;
   int          m_last;
   int          mg;
   function automatic int grant();
      if (!b4.mode) return (int'(b4.sel) < N && b4.in_valid[b4.sel]) ? int'(b4.sel) : -1;
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (m_last + i) % N;
         if (b4.in_valid[c]) return c;
      end
      return -1;
   endfunction
   function automatic logic [N-1:0] exp_ready();
      int gg;
      gg = grant();
      if (!rst_n || gg < 0 || (m_valid && !b4.out_ready)) return '0;
      return N'(1) << gg;
   endfunction
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_data <= '0;
         m_src <= 0;
         m_last <= N - 1;
      end else if (!m_valid || b4.out_ready) begin
         mg = grant();
         m_valid <= (mg >= 0);
         if (mg >= 0) begin
            m_data <= b4.in_data[mg*32 +: 32];
            m_src <= mg;
            m_last <= mg;
         end
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rand_data();
      for (int k = 0; k < N; k++) b4.in_data[k*32 +: 32] = $urandom;
   endtask
   task automatic test_reset();
      #1;
      b4.mode = 1'b1; b4.sel = '0; b4.in_valid = '1; b4.out_ready = 1'b1; rand_data();
      b3.mode = 1'b0; b3.sel = '0; b3.in_valid = '0; b3.out_ready = 1'b1; b3.in_data = '0;
      rst_n = 1'b0;
      tick();
      checks++; if (b4.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", b4.out_valid); end
      checks++; if (b4.out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", b4.out_data); end
      checks++; if (b4.out_src !== 2'd0) begin errors++; $display("FAIL reset_src: got %0d want 0", b4.out_src); end
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL reset_ready: got %b want 0000", b4.in_ready); end
      b4.in_valid = '0;
      rst_n = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL idle_ready: got %b want 0000", b4.in_ready); end
   endtask
   task automatic test_explicit();
      rand_data();
      b4.mode = 1'b0; b4.sel = 2'd2; b4.in_valid = 4'b0100; b4.out_ready = 1'b1;
      b4.in_data[64 +: 32] = 32'hDEADBEEF;
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL explicit_ready: got %b want 0100", b4.in_ready); end
      tick();
      checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL explicit_valid: got %b want 1", b4.out_valid); end
      checks++; if (b4.out_data !== 32'hDEADBEEF) begin errors++; $display("FAIL explicit_data: got %h want deadbeef", b4.out_data); end
      checks++; if (b4.out_src !== 2'd2) begin errors++; $display("FAIL explicit_src: got %0d want 2", b4.out_src); end
   endtask
   task automatic test_stall();
      b4.out_ready = 1'b0;
      b4.in_data[64 +: 32] = 32'h12345678;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b4.in_ready !== 4'b0000) begin errors++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, b4.in_ready); end
         tick();
         checks++; if (b4.out_data !== 32'hDEADBEEF || b4.out_valid !== 1'b1) begin errors++; $display("FAIL stall_hold[%0d]: got %h/%b want deadbeef/1", c, b4.out_data, b4.out_valid); end
      end
      b4.out_ready = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 4'b0100) begin errors++; $display("FAIL unstall_ready: got %b want 0100", b4.in_ready); end
      tick();
      checks++; if (b4.out_data !== 32'h12345678 || b4.out_src !== 2'd2) begin errors++; $display("FAIL unstall_data: got %h/%0d want 12345678/2", b4.out_data, b4.out_src); end
      b4.in_valid = '0;
      tick();
      checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 32'h12345678) begin errors++; $display("FAIL drain: got %b/%h want 0/12345678", b4.out_valid, b4.out_data); end
   endtask
   task automatic test_round_robin();
      int exp_src[6] = '{0, 1, 2, 3, 0, 1};
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b1;
      for (int k = 0; k < N; k++) b4.in_data[k*32 +: 32] = 32'(k + 1);
      for (int c = 0; c < 6; c++) begin
         #1;
         checks++; if (b4.in_ready !== (4'b0001 << exp_src[c])) begin errors++; $display("FAIL rr_ready[%0d]: got %b want ch%0d", c, b4.in_ready, exp_src[c]); end
         tick();
         checks++; if (int'(b4.out_src) != exp_src[c] || b4.out_data !== 32'(exp_src[c] + 1)) begin errors++; $display("FAIL rr_out[%0d]: got src %0d data %h want src %0d", c, b4.out_src, b4.out_data, exp_src[c]); end
      end
   endtask
   task automatic test_sparse();
      int exp_src[3] = '{3, 0, 3};
      b4.in_valid = 4'b1001;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++; if (b4.in_ready !== (4'b0001 << exp_src[c])) begin errors++; $display("FAIL sparse_ready[%0d]: got %b want ch%0d", c, b4.in_ready, exp_src[c]); end
         tick();
         checks++; if (int'(b4.out_src) != exp_src[c] || b4.out_data !== 32'(exp_src[c] + 1)) begin errors++; $display("FAIL sparse_out[%0d]: got src %0d data %h want src %0d", c, b4.out_src, b4.out_data, exp_src[c]); end
      end
   endtask
   task automatic test_n3();
      b3.mode = 1'b0; b3.in_valid = 3'b111; b3.out_ready = 1'b1; b3.sel = 2'd3;
      b3.in_data = {32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
      #1;
      checks++; if (b3.in_ready !== 3'b000) begin errors++; $display("FAIL n3_oor_ready: got %b want 000", b3.in_ready); end
      tick(); tick();
      checks++; if (b3.out_valid !== 1'b0) begin errors++; $display("FAIL n3_oor_valid: got %b want 0", b3.out_valid); end
      b3.sel = 2'd1;
      #1;
      checks++; if (b3.in_ready !== 3'b010) begin errors++; $display("FAIL n3_ready: got %b want 010", b3.in_ready); end
      tick();
      checks++; if (b3.out_valid !== 1'b1 || b3.out_data !== 32'hC1C1C1C1 || b3.out_src !== 2'd1) begin errors++; $display("FAIL n3_out: got %b/%h/%0d want 1/c1c1c1c1/1", b3.out_valid, b3.out_data, b3.out_src); end
   endtask
   task automatic test_async_reset();
      rand_data();
      b4.mode = 1'b1; b4.in_valid = 4'b1111; b4.out_ready = 1'b0;
      tick();
      checks++; if (b4.out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b want 1", b4.out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (b4.out_valid !== 1'b0 || b4.out_data !== 32'h0 || b4.out_src !== 2'd0) begin errors++; $display("FAIL async_reset: got %b/%h/%0d want 0/0/0", b4.out_valid, b4.out_data, b4.out_src); end
      b4.out_ready = 1'b1;
      tick();
      rst_n = 1'b1;
      #1;
      checks++; if (b4.in_ready !== 4'b0001) begin errors++; $display("FAIL post_reset_ready: got %b want 0001", b4.in_ready); end
      tick();
      checks++; if (b4.out_src !== 2'd0 || b4.out_data !== b4.in_data[31:0]) begin errors++; $display("FAIL post_reset_out: got %0d/%h want 0/%h", b4.out_src, b4.out_data, b4.in_data[31:0]); end
   endtask
   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rand_data();
         b4.mode = 1'($urandom_range(0, 1));
         b4.sel = 2'($urandom_range(0, 3));
         b4.in_valid = 4'($urandom);
         b4.out_ready = ($urandom_range(0, 3) != 0);
         #1;
         checks++; if (b4.in_ready !== exp_ready()) begin errors++; $display("FAIL rand_ready[%0d]: got %b want %b", c, b4.in_ready, exp_ready()); end
         tick();
         checks++; if (b4.out_valid !== m_valid || int'(b4.out_src) != m_src || b4.out_data !== m_data) begin errors++; $display("FAIL rand_out[%0d]: got %b/%0d/%h want %b/%0d/%h", c, b4.out_valid, b4.out_src, b4.out_data, m_valid, m_src, m_data); end
      end
   endtask
   initial begin
      test_reset();
      test_explicit();
      test_stall();
      test_round_robin();
      test_sparse();
      test_n3();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mux_rr_n.md
Name: mux_rr_n

Overview:
- Parametrised N-input, W-bit registered multiplexer for the ALU32 datapath and its operand/result steering.
- Selects one source per cycle, either by explicit select or by fair round-robin among valid sources.
- Registers the chosen word with a valid/ready handshake so downstream stalls hold data.
- Direct generalisation of the combinational 4:1 bit mux to wide words, arbitrary width and depth, and flow control.

Parameters:
- W, 32, data width per channel (>=1).
- N, 4, number of input channels (>=2; need not be a power of two).
- SW, $clog2(N), select/source-index width (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  N*W  channel k occupies bits [k*W+W-1 : k*W].
- in_valid  input  N  channel k has a word offered.
- in_ready  output  N  one-hot; channel k's word is taken this cycle.
- mode  input  1  0 = explicit select, 1 = round-robin.
- sel  input  SW  channel index used when mode=0.
- out_data  output  W  registered selected word.
- out_valid  output  1  out_data holds an untaken word.
- out_ready  input  1  downstream accepts out_data.
- out_src  output  SW  index of the channel that produced out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_src=0, internal last-grant pointer last=N-1. in_ready is combinational, so it is 0 during reset.
- Load enable: le = !out_valid || out_ready. The output register accepts a new word only when le=1.
- Grant g (combinational, same cycle):
  - mode=0: g=sel if sel<N and in_valid[sel]. Otherwise there is no grant. An out-of-range sel never grants and never produces X.
  - mode=1: g is the first k with in_valid[k]=1, scanning (last+1) mod N, (last+2) mod N, … wrapping, ending at last. No valid input means no grant.
- in_ready = onehot(g) & le. At most one bit is set, and none when there is no grant or le=0.
- Transfer on posedge when a grant exists and le=1:
  - out_data <= in_data[g]; out_src <= g; out_valid <= 1.
  - last <= g, in both modes.
- Latency: one cycle from input handshake to out_valid.
- Drain/refill: out_valid && out_ready with no grant gives out_valid <= 0; out_data and out_src hold their last values. out_valid && out_ready with a grant refills in the same cycle, giving full throughput of 1 word/cycle.
- Stall: out_valid && !out_ready holds out_data, out_src and out_valid stable and forces in_ready=0.
- Mode or sel changes take effect combinationally that cycle. They never corrupt a word already held in the output register. last is preserved across mode switches.
- Reset mid-operation: a pending out word is discarded and the pointer returns to N-1.
- Fairness: in mode=1, with all channels continuously valid and out_ready=1, grants cycle 0,1,…,N-1,0… with no channel starved for more than N-1 transfers.

Test Plan:
- Reset, then mode=0, sel=2, in_valid=4'b0100, ch2=32'hDEADBEEF, out_ready=1 → in_ready=4'b0100; next cycle out_valid=1, out_data=DEADBEEF, out_src=2.
- Stall: out_valid=1, out_ready=0 for 3 cycles while ch2 changes to 32'h12345678 → out_data stays DEADBEEF, in_ready=0; when out_ready=1 the new word appears the following cycle.
- Round-robin: mode=1, in_valid=4'b1111, channel k holds k+1, out_ready=1 for 6 cycles → out_src sequence 0,1,2,3,0,1 and out_data 1,2,3,4,1,2.
- Sparse round-robin: mode=1, last=1, in_valid=4'b1001 → grant 3, then grant 0, then 3; channels 1 and 2 are never granted.
- N=3 instance, mode=0, sel=3 with all valid → in_ready=0 and out_valid stays 0. With sel=1 → ch1 is passed.
- Assert rst_n=0 mid-stream while out_valid=1 → out_valid, out_data and out_src are 0 immediately (asynchronous). After release in mode=1 with all valid, the first grant is channel 0.
